dac_frame_scheduler: RTL
========================

DAC_FRAME_SCHEDULER -- requirements
Module: dac_frame_scheduler

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, stereo frames buffered; legal range 2..7.
REQ-002 Parameter: HOLD_ON_UNDERRUN, default 0; 0 = output zero on underrun, 1 = repeat last frame.
REQ-003 clk  input  1  system/bit clock; same clock that drives the DAC serializer.
REQ-004 rst_n  input  1  asynchronous, active-low reset; same reset that drives the DAC serializer.
REQ-005 en_i  input  1  playback enable, level-sensitive.
REQ-006 s_valid_i  input  1  upstream frame valid.
REQ-007 s_left_i  input  16  signed left sample.
REQ-008 s_right_i  input  16  signed right sample.
REQ-009 s_ready_o  output  1  FIFO can accept a frame.
REQ-010 dac_data_o  output  16  signed sample to the DAC serializer data input.
REQ-011 slot_o  output  5  current slot counter value.
REQ-012 underrun_o  output  1  one-cycle pulse on a missed frame.
REQ-013 level_o  output  3  FIFO occupancy in frames.
REQ-014 state_o  output  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN, 3 STOP.

Function
REQ-015 slot_o SHALL be a 5-bit free-running counter: +1 every clk from reset, wraps 31->0, independent of state.
- Matches the serializer: it latches left at slot 0 and right at slot 16.
REQ-016 A frame SHALL be pushed on any clk where s_valid_i && s_ready_o.
REQ-017 s_ready_o SHALL be !full, computed from registered occupancy.
- A pop on the same cycle does not raise s_ready_o.
REQ-018 A frame SHALL be popped only on the clk edge where slot_o==31, in RUN, with FIFO non-empty.
REQ-019 Simultaneous push and pop SHALL leave level_o unchanged; FIFO order SHALL be strictly first-in first-out.
REQ-020 FSM transitions SHALL be:
- IDLE->PRIME when en_i==1.
- PRIME->RUN at the slot_o==31 edge when level_o>=2.
- PRIME->IDLE when en_i==0.
- RUN->STOP when en_i==0.
- STOP->IDLE at the next slot_o==31 edge.
REQ-021 At the RUN slot-31 edge with a pop, dac_data_o SHALL load the popped left sample; the right sample SHALL be held in an internal register.
REQ-022 At the RUN or STOP slot-15 edge, dac_data_o SHALL load the held right sample.
- Timing: left is stable at slot 0, right at slot 16.
REQ-023 Underrun (RUN, slot_o==31, FIFO empty) SHALL pulse underrun_o for exactly one clk, and the FSM SHALL stay in RUN.
REQ-024 On underrun with HOLD_ON_UNDERRUN=0, left and held right SHALL both load 0.
REQ-025 On underrun with HOLD_ON_UNDERRUN=1, left and held right SHALL keep their previous values.
REQ-026 In STOP, no pop SHALL occur; the in-flight right sample SHALL complete, then dac_data_o SHALL load 0 at the slot-31 edge.
REQ-027 In IDLE and PRIME, dac_data_o SHALL be 0 and no pop or underrun SHALL occur.
- Pushes remain allowed in IDLE and PRIME.
REQ-028 On the STOP->IDLE transition, the FIFO SHALL be flushed (level_o->0).
REQ-029 en_i re-asserted while in STOP SHALL NOT abort STOP; the FSM SHALL go IDLE, then to PRIME on the next clk.

Reset
REQ-030 While rst_n==0, the block SHALL be held in its reset state:
- slot_o=0, state IDLE, dac_data_o=0, held right=0.
- FIFO empty (level_o=0), s_ready_o=1, underrun_o=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered frames immediately, with no further pop or underrun pulse.
REQ-032 Counting SHALL resume from slot 0 on the first clk after release.

Verification
REQ-033 Push 3 frames in IDLE, then en_i=1 -> RUN at the next slot-31 edge, pops begin.
- Check: dac_data_o equals frame0 left at slot 0 and frame0 right at slot 16.
REQ-034 Push frames 0x1234/0xABCD then 0x7FFF/0x8000, enable -> DAC input equals, in order:
- 0x1234 at slot 0, 0xABCD at slot 16, 0x7FFF at next slot 0, 0x8000 at next slot 16.
REQ-035 FIFO_DEPTH=4, fill to 4 -> s_ready_o=0.
- Push held at the slot-31 pop edge is not accepted; s_ready_o=1 the next cycle.
REQ-036 Starve the FIFO in RUN -> single underrun_o pulse per missed frame.
- dac_data_o=0 (HOLD=0) or last left/right repeated (HOLD=1).
REQ-037 Drop en_i at slot 5 -> right sample still output at slot 16.
- dac_data_o=0 from slot 0; state IDLE; level_o=0.
REQ-038 Assert rst_n=0 at slot 20 of RUN with 2 frames buffered -> all outputs take reset values immediately.
- After release, slot_o counts from 0.

Source files
------------

// File: rtl/dac_frame_scheduler.sv
`default_nettype none
// dac_frame_scheduler: buffers stereo frames in a small FIFO and feeds a 32-slot
// DAC serializer (left latched at slot 0, right at slot 16). Rev 1.0
module dac_frame_scheduler #(
    parameter int FIFO_DEPTH       = 4,
    parameter bit HOLD_ON_UNDERRUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        s_valid_i,
    input  logic [15:0] s_left_i,
    input  logic [15:0] s_right_i,
    output logic        s_ready_o,
    output logic [15:0] dac_data_o,
    output logic [4:0]  slot_o,
    output logic        underrun_o,
    output logic [2:0]  level_o,
    output logic [1:0]  state_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [4:0]       slot_q;
    logic [1:0]       state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
    logic [15:0]      mem_l [FIFO_DEPTH];
    logic [15:0]      mem_r [FIFO_DEPTH];
    logic [15:0]      dac_q, left_q, right_q;
    logic             underrun_q;

    logic slot31, slot15, full, push, pop, under, flush;

    assign slot31 = (slot_q == 5'd31);
    assign slot15 = (slot_q == 5'd15);
    assign full   = (count_q == 3'(FIFO_DEPTH));
    assign push   = s_valid_i && !full;
    assign pop    = (state_q == ST_RUN) && slot31 && (count_q != 3'd0);
    assign under  = (state_q == ST_RUN) && slot31 && (count_q == 3'd0);
    assign flush  = (state_q == ST_STOP) && slot31;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push coinciding with the flush lands in entry 0 of the emptied FIFO.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_addr  = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_addr  = '0;
            wr_ptr_d = push ? PTR_W'(1) : '0;
            count_d  = push ? 3'd1 : 3'd0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + 3'(push) - 3'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_i) state_d = ST_PRIME;
            ST_PRIME: begin
                if (!en_i)                           state_d = ST_IDLE;
                else if (slot31 && count_q >= 3'd2)  state_d = ST_RUN;
            end
            ST_RUN:   if (!en_i) state_d = ST_STOP;
            ST_STOP:  if (slot31) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_addr] <= s_left_i;
            mem_r[wr_addr] <= s_right_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= 5'd0;
            state_q    <= ST_IDLE;
            count_q    <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_q + 5'd1;
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            underrun_q <= under;
        end
    end

    // left_q remembers the last left sample so a held underrun can repeat it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q   <= 16'd0;
            left_q  <= 16'd0;
            right_q <= 16'd0;
        end else if (state_q == ST_IDLE || state_q == ST_PRIME) begin
            dac_q <= 16'd0;
        end else if (pop) begin
            dac_q   <= mem_l[rd_ptr_q];
            left_q  <= mem_l[rd_ptr_q];
            right_q <= mem_r[rd_ptr_q];
        end else if (under) begin
            if (HOLD_ON_UNDERRUN) begin
                dac_q <= left_q;
            end else begin
                dac_q   <= 16'd0;
                left_q  <= 16'd0;
                right_q <= 16'd0;
            end
        end else if (slot15) begin
            dac_q <= right_q;
        end else if (flush) begin
            dac_q   <= 16'd0;
            left_q  <= 16'd0;
            right_q <= 16'd0;
        end
    end

    assign s_ready_o  = !full;
    assign dac_data_o = dac_q;
    assign slot_o     = slot_q;
    assign underrun_o = underrun_q;
    assign level_o    = count_q;
    assign state_o    = state_q;

endmodule
`default_nettype wire
